// File: rtl/pkt_fifo_pkg.sv
// Shared types for the store-and-forward packet FIFO: write/read FSM states and
// the width of the optional statistics counters.
package pkt_fifo_pkg;

    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        W_IDLE,
        W_PKT,
        W_DROP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_LOAD,
        R_SEND
    } rd_state_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// Contents are not reset; the pointers around it decide what is valid.
module sdp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: storage arrays carry no reset; clearing them would cost a write per
    // word and buys nothing because no entry is read before it is written.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/pkt_fifo_sf.sv
// Store-and-forward packet FIFO: a packet is released only once its eop is stored;
// bad packets are dropped whole. Define PKT_FIFO_SF_STAT_EN to add drop/packet counters.
module pkt_fifo_sf
    import pkt_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int PKT_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    input  logic              b_rdy,
`ifdef PKT_FIFO_SF_STAT_EN
    output logic [STAT_W-1:0] drop_cnt,
    output logic [STAT_W-1:0] pkt_cnt,
`endif
    output logic              pkt_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(PKT_DEPTH);
    localparam logic [PW-1:0] DEPTH_P     = PW'(DEPTH);
    localparam logic [LW:0]   PKT_DEPTH_P = (LW + 1)'(PKT_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    wr_state_e         wr_state_q, wr_state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d, rd_ptr_q, rd_ptr_d;
    logic              pkt_drop_q, pkt_drop_d;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic              ram_full_spec, ram_full_cmt;

    logic [PW-1:0]     len_mem [PKT_DEPTH];
    logic [LW:0]       lf_wr_q, lf_wr_d, lf_rd_q, lf_rd_d, pkt_stored_q, pkt_stored_d;
    logic              lf_push, lf_pop, lf_full, lf_empty;
    logic [PW-1:0]     lf_push_len;

    rd_state_e         rd_state_q, rd_state_d;
    logic [PW-1:0]     rd_rem_q, rd_rem_d;
    logic [AW-1:0]     rd_fetch_q, rd_fetch_d;
    logic              fetch, room;
    logic              fetch_vld_q, fetch_sop_q, fetch_sop_d, fetch_eop_q, fetch_eop_d;
    logic [DATA_W-1:0] ram_rdata;
    beat_t             in_beat;
    beat_t [1:0]       buf_q, buf_d;
    logic [1:0]        buf_cnt_q, buf_cnt_d, occ;
    logic              xfer, eop_xfer;

    assign ram_full_spec = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    assign ram_full_cmt  = (wr_cmt_q - rd_ptr_q) == DEPTH_P;
    // A packet holds its slot until its eop leaves, so buffered output counts too.
    assign lf_full       = pkt_stored_q == PKT_DEPTH_P;
    assign lf_empty      = lf_wr_q == lf_rd_q;

    // NOTE: every signal assigned here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_cmt_d    = wr_cmt_q;
        pkt_drop_d  = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = wr_ptr_q[AW-1:0];
        lf_push     = 1'b0;
        lf_push_len = wr_ptr_q + 1'b1 - wr_cmt_q;
        if (din_vld) begin
            if (din_sop) begin
                // Any sop restarts at the committed pointer, abandoning an open packet.
                wr_ptr_d = wr_cmt_q;
                if (wr_state_q == W_PKT) pkt_drop_d = 1'b1;
                if (lf_full || ram_full_cmt) begin
                    pkt_drop_d = 1'b1;
                    wr_state_d = din_eop ? W_IDLE : W_DROP;
                end else begin
                    ram_we    = 1'b1;
                    ram_waddr = wr_cmt_q[AW-1:0];
                    wr_ptr_d  = wr_cmt_q + 1'b1;
                    if (din_eop) begin
                        wr_cmt_d    = wr_cmt_q + 1'b1;
                        lf_push     = 1'b1;
                        lf_push_len = PW'(1);
                        wr_state_d  = W_IDLE;
                    end else begin
                        wr_state_d = W_PKT;
                    end
                end
            end else begin
                case (wr_state_q)
                    W_PKT: begin
                        if (ram_full_spec) begin
                            wr_ptr_d   = wr_cmt_q;
                            pkt_drop_d = 1'b1;
                            wr_state_d = din_eop ? W_IDLE : W_DROP;
                        end else begin
                            ram_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            if (din_eop) begin
                                wr_cmt_d   = wr_ptr_q + 1'b1;
                                lf_push    = 1'b1;
                                wr_state_d = W_IDLE;
                            end
                        end
                    end
                    W_DROP:  if (din_eop) wr_state_d = W_IDLE;
                    default: ;
                endcase
            end
        end
    end

    assign occ  = buf_cnt_q + {1'b0, fetch_vld_q} - {1'b0, xfer};
    assign room = occ < 2'd2;

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_rem_d    = rd_rem_q;
        rd_fetch_d  = rd_fetch_q;
        lf_pop      = 1'b0;
        fetch       = 1'b0;
        fetch_sop_d = 1'b0;
        fetch_eop_d = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (!lf_empty) begin
                    lf_pop     = 1'b1;
                    rd_rem_d   = len_mem[lf_rd_q[LW-1:0]];
                    rd_state_d = R_LOAD;
                end
            end
            R_LOAD, R_SEND: begin
                if (room) begin
                    fetch       = 1'b1;
                    fetch_sop_d = rd_state_q == R_LOAD;
                    fetch_eop_d = rd_rem_q == PW'(1);
                    rd_fetch_d  = rd_fetch_q + 1'b1;
                    rd_rem_d    = rd_rem_q - 1'b1;
                    rd_state_d  = (rd_rem_q == PW'(1)) ? R_IDLE : R_SEND;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign in_beat  = '{data: ram_rdata, sop: fetch_sop_q, eop: fetch_eop_q};
    assign xfer     = (buf_cnt_q != 2'd0) && b_rdy;
    assign eop_xfer = xfer && buf_q[0].eop;

    // Entry 0 drives the outputs; it only changes on a transfer or when empty.
    always_comb begin
        buf_d     = buf_q;
        buf_cnt_d = buf_cnt_q;
        if (xfer) begin
            buf_d[0]  = buf_q[1];
            buf_cnt_d = buf_cnt_q - 2'd1;
        end
        if (fetch_vld_q) begin
            buf_d[buf_cnt_d[0]] = in_beat;
            buf_cnt_d           = buf_cnt_d + 2'd1;
        end
    end

    assign rd_ptr_d     = rd_ptr_q + {{(PW-1){1'b0}}, xfer};
    assign lf_wr_d      = lf_wr_q + {{LW{1'b0}}, lf_push};
    assign lf_rd_d      = lf_rd_q + {{LW{1'b0}}, lf_pop};
    assign pkt_stored_d = pkt_stored_q + {{LW{1'b0}}, lf_push} - {{LW{1'b0}}, eop_xfer};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q   <= W_IDLE;
            wr_ptr_q     <= '0;
            wr_cmt_q     <= '0;
            rd_ptr_q     <= '0;
            pkt_drop_q   <= 1'b0;
            lf_wr_q      <= '0;
            lf_rd_q      <= '0;
            pkt_stored_q <= '0;
            rd_state_q   <= R_IDLE;
            rd_rem_q     <= '0;
            rd_fetch_q   <= '0;
            fetch_vld_q  <= 1'b0;
            fetch_sop_q  <= 1'b0;
            fetch_eop_q  <= 1'b0;
            buf_q        <= '0;
            buf_cnt_q    <= '0;
        end else begin
            wr_state_q   <= wr_state_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_cmt_q     <= wr_cmt_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_drop_q   <= pkt_drop_d;
            lf_wr_q      <= lf_wr_d;
            lf_rd_q      <= lf_rd_d;
            pkt_stored_q <= pkt_stored_d;
            rd_state_q   <= rd_state_d;
            rd_rem_q     <= rd_rem_d;
            rd_fetch_q   <= rd_fetch_d;
            fetch_vld_q  <= fetch;
            fetch_sop_q  <= fetch_sop_d;
            fetch_eop_q  <= fetch_eop_d;
            buf_q        <= buf_d;
            buf_cnt_q    <= buf_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lf_push) len_mem[lf_wr_q[LW-1:0]] <= lf_push_len;
    end

    sdp_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(AW)
    ) u_data_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(din),
        .re   (fetch),
        .raddr(rd_fetch_q),
        .rdata(ram_rdata)
    );

    assign dout     = buf_q[0].data;
    assign dout_vld = buf_cnt_q != 2'd0;
    assign dout_sop = buf_q[0].sop;
    assign dout_eop = buf_q[0].eop;
    assign pkt_drop = pkt_drop_q;

`ifdef PKT_FIFO_SF_STAT_EN
    logic [STAT_W-1:0] drop_cnt_q, drop_cnt_d, pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (pkt_drop_q && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
        if (eop_xfer) pkt_cnt_d = pkt_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_fifo_sf.sv
// Self-checking bench for pkt_fifo_sf (DEPTH=16, PKT_DEPTH=2): directed cases plus
// randomized packets scored against a packet-level model. Honours PKT_FIFO_SF_STAT_EN.
`timescale 1ns/1ps
module tb_pkt_fifo_sf;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int PKT_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] din = '0;
    logic              din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              dout_vld, dout_sop, dout_eop;
    logic              b_rdy = 1'b1;
    logic              pkt_drop;
`ifdef PKT_FIFO_SF_STAT_EN
    logic [15:0]       drop_cnt, pkt_cnt;
`endif

    pkt_fifo_sf #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .PKT_DEPTH(PKT_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .din_vld (din_vld),
        .din_sop (din_sop),
        .din_eop (din_eop),
        .dout    (dout),
        .dout_vld(dout_vld),
        .dout_sop(dout_sop),
        .dout_eop(dout_eop),
        .b_rdy   (b_rdy),
`ifdef PKT_FIFO_SF_STAT_EN
        .drop_cnt(drop_cnt),
        .pkt_cnt (pkt_cnt),
`endif
        .pkt_drop(pkt_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       e;
        int         cyc;
    } beat_t;

    beat_t      out_q[$], exp_q[$], last_out[$];
    logic [7:0] sent_q[$];
    int         n_checks = 0, n_errors = 0;
    int         cyc = 0, drops = 0, eops_seen = 0;
    int         rdy_mode = 0, last_cyc = 0, first_cyc = 0;
    logic       prev_stall = 1'b0, prev_sop = 1'b0, prev_eop = 1'b0;
    logic [7:0] prev_dout = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records transfers, counts drop pulses, checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_vld", 32'(dout_vld), 32'd1);
                check("stall_dout", 32'(dout), 32'(prev_dout));
                check("stall_sop", 32'(dout_sop), 32'(prev_sop));
                check("stall_eop", 32'(dout_eop), 32'(prev_eop));
            end
            if (dout_vld && b_rdy) begin
                out_q.push_back('{d: dout, s: dout_sop, e: dout_eop, cyc: cyc});
                if (dout_eop) eops_seen <= eops_seen + 1;
            end
            if (pkt_drop) drops <= drops + 1;
            prev_stall <= dout_vld && !b_rdy;
            prev_dout  <= dout;
            prev_sop   <= dout_sop;
            prev_eop   <= dout_eop;
        end
    end

    task automatic step();
        case (rdy_mode)
            1:       b_rdy = 1'($urandom_range(0, 1));
            2:       b_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic s, input logic e);
        din = d; din_sop = s; din_eop = e; din_vld = 1'b1;
        step();
        last_cyc = cyc;
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [7:0] first, input bit rnd);
        logic [7:0] d;
        sent_q.delete();
        for (int i = 0; i < len; i++) begin
            d = rnd ? 8'($urandom) : first + 8'(i);
            sent_q.push_back(d);
            drive(d, i == 0, i == len - 1);
        end
    endtask

    // Model: a stored packet comes out unchanged, sop on its first beat, eop on its last.
    task automatic expect_pkt();
        foreach (sent_q[i])
            exp_q.push_back('{d: sent_q[i], s: (i == 0), e: (i == sent_q.size() - 1), cyc: 0});
    endtask

    task automatic drain(input string tag, input int budget);
        int n = exp_q.size();
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            step();
            k++;
        end
        repeat (6) step();
        last_out  = out_q;
        first_cyc = (out_q.size() > 0) ? out_q[0].cyc : -1;
        check({tag, "_count"}, 32'(out_q.size()), 32'(n));
        for (int i = 0; i < n && i < out_q.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), 32'(out_q[i].d), 32'(exp_q[i].d));
            check($sformatf("%s_sop%0d", tag, i), 32'(out_q[i].s), 32'(exp_q[i].s));
            check($sformatf("%s_eop%0d", tag, i), 32'(out_q[i].e), 32'(exp_q[i].e));
        end
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int d0, eop_at, n0, k, npk, len, exp_drops;

        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_vld", 32'(dout_vld), 32'd0);
        check("rst_sop", 32'(dout_sop), 32'd0);
        check("rst_eop", 32'(dout_eop), 32'd0);
        check("rst_drop", 32'(pkt_drop), 32'd0);
        rst = 1'b0;
        step();

        // 5-beat packet, latency from eop write to first output beat.
        d0 = drops;
        send_pkt(5, 8'h10, 1'b0);
        eop_at = last_cyc;
        expect_pkt();
        drain("t1", 40);
        check("t1_latency", 32'(first_cyc - eop_at), 32'd3);
        check("t1_drops", 32'(drops - d0), 32'd0);

        // Oversized packet dropped once, next packet intact.
        d0 = drops;
        send_pkt(150, 8'h00, 1'b0);
        send_pkt(3, 8'hA0, 1'b0);
        expect_pkt();
        drain("t2", 40);
        check("t2_drops", 32'(drops - d0), 32'd1);

        // Stray beat ignored; sop mid-packet aborts the open packet.
        d0 = drops;
        drive(8'h77, 1'b0, 1'b0);
        drive(8'h01, 1'b1, 1'b0);
        drive(8'h02, 1'b0, 1'b0);
        send_pkt(2, 8'h05, 1'b0);
        expect_pkt();
        drain("t3", 40);
        check("t3_drops", 32'(drops - d0), 32'd1);

        // Two 4-beat packets drained with b_rdy pattern 1,0,0,1.
        b_rdy = 1'b0;
        send_pkt(4, 8'h20, 1'b0);
        expect_pkt();
        send_pkt(4, 8'h28, 1'b0);
        expect_pkt();
        rdy_mode = 2;
        drain("t4", 80);
        rdy_mode = 0;
        b_rdy = 1'b1;

        // Packet-count limit: third 1-beat packet dropped while output is blocked.
        d0 = drops;
        b_rdy = 1'b0;
        send_pkt(1, 8'h31, 1'b0);
        expect_pkt();
        send_pkt(1, 8'h32, 1'b0);
        expect_pkt();
        send_pkt(1, 8'h33, 1'b0);
        repeat (6) step();
        check("t5_drops", 32'(drops - d0), 32'd1);
        b_rdy = 1'b1;
        drain("t5", 40);

        // Back-to-back stored packets: contiguous beats, at most one idle cycle between.
        b_rdy = 1'b0;
        send_pkt(3, 8'h40, 1'b0);
        expect_pkt();
        send_pkt(3, 8'h50, 1'b0);
        expect_pkt();
        repeat (6) step();
        b_rdy = 1'b1;
        drain("t6", 40);
        if (last_out.size() == 6) begin
            check("t6_pkt1_span", 32'(last_out[2].cyc - last_out[0].cyc), 32'd2);
            check("t6_pkt2_span", 32'(last_out[5].cyc - last_out[3].cyc), 32'd2);
            check("t6_gap_le1", 32'(last_out[3].cyc - last_out[2].cyc <= 2), 32'd1);
        end

        // Length boundary: DEPTH beats fits, DEPTH+1 is dropped.
        d0 = drops;
        send_pkt(DEPTH, 8'h80, 1'b0);
        expect_pkt();
        drain("t7a", 60);
        send_pkt(DEPTH + 1, 8'h90, 1'b0);
        drain("t7b", 20);
        check("t7_drops", 32'(drops - d0), 32'd1);

        // Randomized packets with random backpressure.
        rdy_mode = 1;
        for (int it = 0; it < 12; it++) begin
            d0 = drops;
            exp_drops = 0;
            npk = $urandom_range(1, 2);
            for (int p = 0; p < npk; p++) begin
                len = (npk == 1) ? $urandom_range(1, 20) : $urandom_range(1, 8);
                send_pkt(len, 8'h00, 1'b1);
                if (len <= DEPTH) expect_pkt();
                else exp_drops++;
                repeat ($urandom_range(0, 2)) step();
            end
            drain($sformatf("rnd%0d", it), 200);
            check($sformatf("rnd%0d_drops", it), 32'(drops - d0), 32'(exp_drops));
        end
        rdy_mode = 0;
        b_rdy = 1'b1;

`ifdef PKT_FIFO_SF_STAT_EN
        check("stat_drop_cnt", 32'(drop_cnt), 32'(drops));
        check("stat_pkt_cnt", 32'(pkt_cnt), 32'(eops_seen & 16'hFFFF));
`endif

        // Reset mid-output of an 8-beat packet.
        send_pkt(8, 8'hC0, 1'b0);
        k = 0;
        while (out_q.size() < 3 && k < 40) begin
            step();
            k++;
        end
        check("t8_started", 32'(out_q.size() >= 3), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t8_vld", 32'(dout_vld), 32'd0);
        check("t8_dout", 32'(dout), 32'd0);
        n0 = out_q.size();
        repeat (20) step();
        check("t8_no_more", 32'(out_q.size()), 32'(n0));
`ifdef PKT_FIFO_SF_STAT_EN
        check("t8_drop_cnt", 32'(drop_cnt), 32'd0);
        check("t8_pkt_cnt", 32'(pkt_cnt), 32'd0);
`endif
        out_q.delete();
        exp_q.delete();

        send_pkt(2, 8'hE0, 1'b0);
        expect_pkt();
        drain("t9", 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
